// File: rtl/rtc_ticker.sv
// rtc_ticker: free-running BCD calendar clock with a per-field carry FSM and atomic 65-bit output.
module rtc_ticker #(
    parameter int CLK_HZ = 12000000
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [64:0] RTC_IN,
    input  logic        RTC_IN_VALID,
    output logic [64:0] RTC_OUT,
    output logic        SEC_PULSE,
    output logic        BUSY
);
    localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
    localparam logic [55:0] RST_TIME = 56'h06_00_01_01_000000;

    typedef enum logic [2:0] {IDLE, S_SEC, S_MIN, S_HOUR, S_DAY, S_MON, S_YEAR, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [PW-1:0] ps_q;
    logic        vld_q, tog_q, pulse_q;
    logic [55:0] w_q, w_d, out_q;
    logic        tick, load, carry, leap;
    logic [7:0]  wday, year, mon, day, hour, mins, sec, mlen;
    logic        unused_in;

    function automatic logic [7:0] inc(input logic [7:0] v);
        return v[3:0] >= 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign unused_in = ^RTC_IN[64:56];
    assign {wday, year, mon, day, hour, mins, sec} = w_q;
    assign tick = ps_q == PW'(CLK_HZ - 1);
    assign load = RTC_IN_VALID && !vld_q;
    assign leap = year[4] ? (year[3:0] == 4'd2 || year[3:0] == 4'd6)
                          : (year[3:0] == 4'd0 || year[3:0] == 4'd4 || year[3:0] == 4'd8);
    assign mlen = mon == 8'h02 ? (leap ? 8'h29 : 8'h28)
                : (mon == 8'h04 || mon == 8'h06 || mon == 8'h09 || mon == 8'h11) ? 8'h30 : 8'h31;

    always_comb begin
        w_d   = w_q;
        carry = 1'b0;
        case (state_q)
            S_SEC:  begin carry = sec >= 8'h59;  w_d[7:0]   = carry ? 8'h00 : inc(sec);  end
            S_MIN:  begin carry = mins >= 8'h59; w_d[15:8]  = carry ? 8'h00 : inc(mins); end
            S_HOUR: begin carry = hour >= 8'h23; w_d[23:16] = carry ? 8'h00 : inc(hour); end
            S_DAY: begin
                carry       = day >= mlen;
                w_d[31:24]  = carry ? 8'h01 : inc(day);
                w_d[55:48]  = wday >= 8'h06 ? 8'h00 : inc(wday);
            end
            S_MON:  begin carry = mon >= 8'h12;  w_d[39:32] = carry ? 8'h01 : inc(mon);  end
            S_YEAR: w_d[47:40] = year >= 8'h99 ? 8'h00 : inc(year);
            default: ;
        endcase
        state_d = state_q == IDLE   ? (tick ? S_SEC : IDLE)
                : state_q == COMMIT ? IDLE
                : carry             ? state_t'(state_q + 3'd1) : COMMIT;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
            ps_q    <= '0;
            vld_q   <= 1'b0;
            tog_q   <= 1'b0;
            pulse_q <= 1'b0;
            w_q     <= RST_TIME;
            out_q   <= RST_TIME;
        end else begin
            vld_q <= RTC_IN_VALID;
            if (load) begin
                state_q <= IDLE;
                ps_q    <= '0;
                w_q     <= RTC_IN[55:0];
                out_q   <= RTC_IN[55:0];
                tog_q   <= ~tog_q;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                ps_q    <= tick ? '0 : ps_q + 1'b1;
                w_q     <= w_d;
                pulse_q <= state_d == COMMIT;
                // the last field state publishes the whole word at once
                if (state_d == COMMIT) begin
                    out_q <= w_d;
                    tog_q <= ~tog_q;
                end
            end
        end
    end

    assign RTC_OUT   = {tog_q, 8'h40, out_q};
    assign SEC_PULSE = pulse_q;
    assign BUSY      = state_q != IDLE;
endmodule

// File: tb/tb_rtc_ticker.sv
// tb_rtc_ticker: directed checks of reset, carries, leap years, loads and tick timing with CLK_HZ=16.
module tb_rtc_ticker;
    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic [64:0] RTC_IN = '0;
    logic        RTC_IN_VALID = 1'b0;
    logic [64:0] RTC_OUT;
    logic        SEC_PULSE, BUSY;

    int n_cmp = 0, n_err = 0;
    logic tog = 1'b0;
    int k0, kb, np, lat, chg;
    logic prev;

    rtc_ticker #(.CLK_HZ(16)) dut (
        .CLK(CLK), .nRESET(nRESET), .RTC_IN(RTC_IN), .RTC_IN_VALID(RTC_IN_VALID),
        .RTC_OUT(RTC_OUT), .SEC_PULSE(SEC_PULSE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [55:0] v);
        RTC_IN = {1'b1, 8'hA5, v};
        RTC_IN_VALID = 1'b1;
        step(1);
        RTC_IN_VALID = 1'b0;
        tog = ~tog;
    endtask

    // k0: edge of tick, kb: busy cycles, np: pulses, lat: pulse edge relative to tick (+1)
    task automatic tick_wait(output int t0, output int tb, output int tp, output int tl);
        t0 = 0; tb = 0; tp = 0; tl = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (BUSY) begin
                tb++;
                if (t0 == 0) t0 = i;
            end
            if (SEC_PULSE) begin
                tp++;
                tl = i - t0 + 1;
            end
            if (t0 != 0 && !BUSY) break;
        end
        if (tp != 0) tog = ~tog;
    endtask

    function automatic logic [64:0] exp_out(input logic t, input logic [55:0] v);
        return {t, 8'h40, v};
    endfunction

    initial begin
        step(2);
        chk("reset_out", RTC_OUT, {1'b0, 8'h40, 56'h06_00_01_01_000000});
        chk("reset_pulse", 65'(SEC_PULSE), 65'd0);
        chk("reset_busy", 65'(BUSY), 65'd0);
        nRESET = 1'b1;

        tick_wait(k0, kb, np, lat);
        chk("first_tick_edge", 65'(k0), 65'd16);
        chk("first_latency", 65'(lat), 65'd2);
        chk("first_pulses", 65'(np), 65'd1);
        chk("first_out", RTC_OUT, {1'b1, 8'h40, 56'h06_00_01_01_000001});

        load(56'h05_99_12_31_235959);
        chk("load_out", RTC_OUT, exp_out(tog, 56'h05_99_12_31_235959));
        chk("load_no_pulse", 65'(SEC_PULSE), 65'd0);
        tick_wait(k0, kb, np, lat);
        chk("y2k_tick_edge", 65'(k0), 65'd16);
        chk("y2k_busy", 65'(kb), 65'd7);
        chk("y2k_latency", 65'(lat), 65'd7);
        chk("y2k_pulses", 65'(np), 65'd1);
        chk("y2k_out", RTC_OUT, exp_out(tog, 56'h06_00_01_01_000000));

        load(56'h03_24_02_28_235959);
        tick_wait(k0, kb, np, lat);
        chk("leap_busy", 65'(kb), 65'd5);
        chk("leap_out", RTC_OUT, exp_out(tog, 56'h04_24_02_29_000000));

        load(56'h02_23_02_28_235959);
        tick_wait(k0, kb, np, lat);
        chk("nonleap_busy", 65'(kb), 65'd6);
        chk("nonleap_out", RTC_OUT, exp_out(tog, 56'h03_23_03_01_000000));

        load(56'h02_24_04_30_235959);
        tick_wait(k0, kb, np, lat);
        chk("apr_out", RTC_OUT, exp_out(tog, 56'h03_24_05_01_000000));

        load(56'h01_24_01_01_000058);
        tick_wait(k0, kb, np, lat);
        chk("s58_tick_edge", 65'(k0), 65'd16);
        chk("s58_latency", 65'(lat), 65'd2);
        chk("s58_pulses", 65'(np), 65'd1);
        chk("s58_out", RTC_OUT, exp_out(tog, 56'h01_24_01_01_000059));
        tick_wait(k0, kb, np, lat);
        chk("s59_tick_edge", 65'(k0), 65'd14);
        chk("s59_latency", 65'(lat), 65'd3);
        chk("s59_pulses", 65'(np), 65'd1);
        chk("s59_out", RTC_OUT, exp_out(tog, 56'h01_24_01_01_000100));

        load(56'h00_00_01_01_105959);
        step(18);
        chk("mid_hour_busy", 65'(BUSY), 65'd1);
        chk("mid_hour_out", RTC_OUT, exp_out(tog, 56'h00_00_01_01_105959));
        load(56'h03_24_06_15_120000);
        chk("abort_out", RTC_OUT, exp_out(tog, 56'h03_24_06_15_120000));
        chk("abort_no_pulse", 65'(SEC_PULSE), 65'd0);
        chk("abort_idle", 65'(BUSY), 65'd0);
        tick_wait(k0, kb, np, lat);
        chk("abort_tick_edge", 65'(k0), 65'd16);
        chk("abort_pulses", 65'(np), 65'd1);
        chk("abort_next_out", RTC_OUT, exp_out(tog, 56'h03_24_06_15_120001));

        RTC_IN = {1'b0, 8'h00, 56'h02_24_03_05_080000};
        RTC_IN_VALID = 1'b1;
        prev = RTC_OUT[64];
        chg = 0;
        np = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (RTC_OUT[64] !== prev) chg++;
            if (SEC_PULSE) np++;
            prev = RTC_OUT[64];
        end
        RTC_IN_VALID = 1'b0;
        chk("hold_toggles", 65'(chg), 65'd7);
        chk("hold_pulses", 65'(np), 65'd6);
        chk("hold_out", RTC_OUT[55:0], 65'(56'h02_24_03_05_080006));
        chk("hold_const", 65'(RTC_OUT[63:56]), 65'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
